// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    RESET,
    RELEASE,
    RUN,
    QUIESCE,
    HOLD
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One spare bit above the largest terminal count keeps the compare values in range.
  function automatic int cnt_width(input int stage_delay, input int hold_cycles,
                                   input int ack_timeout);
    return $clog2(max3(stage_delay, hold_cycles, ack_timeout)) + 1;
  endfunction

  function automatic bit params_legal(input int num_stages, input int stage_delay,
                                      input int hold_cycles, input int ack_timeout);
    return (num_stages >= 1) && (num_stages <= 8) && (stage_delay >= 1) &&
           (hold_cycles >= 1) && (ack_timeout >= 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asynchronous assertion, two-flop synchronous deassertion.
// Latency: release seen on rst_n_sync two clk edges after arst_n rises; assertion immediate.
// Backpressure: none.
module reset_sync (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n_sync
);

  logic meta;

  // Clear both flops the moment arst_n drops; shift a 1 through on release.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta       <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      meta       <= 1'b1;
      rst_n_sync <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset distributor: releases domains one by one, handles quiesce-then-reset soft resets.
// Latency: stage k released (k+1)*STAGE_DELAY edges after the first edge that sees rst_s high.
// Backpressure: soft reset waits for QUIESCE_ACK, bounded by ACK_TIMEOUT cycles.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  FABRIC_RESET_N,
  input  logic                  SW_RST_REQ,
  input  logic                  QUIESCE_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  QUIESCE_REQ,
  output logic                  RESET_DONE,
  output logic                  BUSY,
  output logic                  TIMEOUT_FLAG
);

  localparam int CNT_W = cnt_width(STAGE_DELAY, HOLD_CYCLES, ACK_TIMEOUT);

  if (!params_legal(NUM_STAGES, STAGE_DELAY, HOLD_CYCLES, ACK_TIMEOUT)) begin : g_param_check
    $error("reset_sequencer: illegal parameter set");
  end

  logic                  rst_s;
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_STAGES-1:0] stage_q, stage_nxt;
  logic                  tflag_q, tflag_nxt;
  logic                  qreq_q, done_q, busy_q;

  reset_sync u_reset_sync (
    .clk        (CLK),
    .arst_n     (FABRIC_RESET_N),
    .rst_n_sync (rst_s)
  );

  // State, counter, stage mask and decoded outputs, all registered.
  always_ff @(posedge CLK or negedge rst_s) begin
    if (!rst_s) begin
      state   <= RESET;
      cnt     <= '0;
      stage_q <= '0;
      tflag_q <= 1'b0;
      qreq_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      stage_q <= stage_nxt;
      tflag_q <= tflag_nxt;
      qreq_q  <= (state_nxt == QUIESCE);
      done_q  <= (state_nxt == RUN);
      busy_q  <= (state_nxt != RUN);
    end
  end

  // Sequencing rules; every exit path clears the counter so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stage_nxt = stage_q;
    tflag_nxt = tflag_q;
    case (state)
      RESET: begin
        // Only clocked here once rst_s is already high.
        state_nxt = RELEASE;
        cnt_nxt   = '0;
      end
      RELEASE: begin
        if (&stage_q) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
          // Shift in a one so the lowest still-held domain is released next.
          stage_nxt = (stage_q << 1) | NUM_STAGES'(1);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (SW_RST_REQ) begin
          state_nxt = QUIESCE;
          tflag_nxt = 1'b0;
          cnt_nxt   = '0;
        end
      end
      QUIESCE: begin
        if (QUIESCE_ACK) begin
          // An ACK on the timeout cycle still counts as a clean drain.
          state_nxt = HOLD;
          stage_nxt = '0;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_nxt = HOLD;
          stage_nxt = '0;
          tflag_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RESET;
        cnt_nxt   = '0;
        stage_nxt = '0;
      end
    endcase
  end

  assign STAGE_RESET_N = stage_q;
  assign QUIESCE_REQ   = qreq_q;
  assign RESET_DONE    = done_q;
  assign BUSY          = busy_q;
  assign TIMEOUT_FLAG  = tflag_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int NS = 3;
  localparam int SD = 4;
  localparam int HC = 8;
  localparam int TO = 16;

  localparam int P_RST  = 0;
  localparam int P_REL  = 1;
  localparam int P_RUN  = 2;
  localparam int P_Q    = 3;
  localparam int P_HOLD = 4;

  logic          CLK;
  logic          FABRIC_RESET_N;
  logic          SW_RST_REQ;
  logic          QUIESCE_ACK;
  logic [NS-1:0] STAGE_RESET_N;
  logic          QUIESCE_REQ;
  logic          RESET_DONE;
  logic          BUSY;
  logic          TIMEOUT_FLAG;

  int tests = 0;
  int fails = 0;
  int n     = 0;   // number of rising CLK edges so far
  bit chk_en = 0;

  // Reference model: phase plus the edge numbers at which each phase began.
  int hi_edges, ph, rel_start, q_start, hold_start;
  bit m_tflag;

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .STAGE_DELAY (SD),
    .HOLD_CYCLES (HC),
    .ACK_TIMEOUT (TO)
  ) dut (
    .CLK            (CLK),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .SW_RST_REQ     (SW_RST_REQ),
    .QUIESCE_ACK    (QUIESCE_ACK),
    .STAGE_RESET_N  (STAGE_RESET_N),
    .QUIESCE_REQ    (QUIESCE_REQ),
    .RESET_DONE     (RESET_DONE),
    .BUSY           (BUSY),
    .TIMEOUT_FLAG   (TIMEOUT_FLAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) n <= n + 1;

  // Model update. The edge being processed is number n+1 (n updates after this block).
  always @(posedge CLK or negedge FABRIC_RESET_N) begin
    int e;
    e = n + 1;
    if (!FABRIC_RESET_N) begin
      hi_edges = 0; ph = P_RST; rel_start = 0; q_start = 0; hold_start = 0; m_tflag = 0;
    end else if (hi_edges < 3) begin
      // Two synchronizer edges, then the first edge that sees the synced reset high.
      hi_edges = hi_edges + 1;
      if (hi_edges == 3) begin ph = P_REL; rel_start = e; end
    end else begin
      case (ph)
        P_REL:  if (e == rel_start + NS * SD + 1) ph = P_RUN;
        P_RUN:  if (SW_RST_REQ) begin ph = P_Q; q_start = e; m_tflag = 0; end
        P_Q: begin
          if (QUIESCE_ACK) begin ph = P_HOLD; hold_start = e; end
          else if (e == q_start + TO) begin ph = P_HOLD; hold_start = e; m_tflag = 1; end
        end
        P_HOLD: if (e == hold_start + HC) begin ph = P_REL; rel_start = e; end
        default: ph = P_RST;
      endcase
    end
  end

  function automatic int exp_stage();
    int k;
    k = 0;
    if (ph == P_REL) begin
      k = (n - rel_start) / SD;
      if (k > NS) k = NS;
    end else if (ph == P_RUN || ph == P_Q) begin
      k = NS;
    end
    return (1 << k) - 1;
  endfunction

  function automatic int exp_qreq();  return (ph == P_Q)   ? 1 : 0; endfunction
  function automatic int exp_done();  return (ph == P_RUN) ? 1 : 0; endfunction
  function automatic int exp_busy();  return (ph == P_RUN) ? 0 : 1; endfunction
  function automatic int exp_tflag(); return m_tflag ? 1 : 0;       endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  // Check DUT and model against a hand-computed value.
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    chk(name, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  task automatic lit_reset_values(input string tag);
    lit({tag, "_stage"}, int'(STAGE_RESET_N), exp_stage(), 0);
    lit({tag, "_qreq"},  int'(QUIESCE_REQ),   exp_qreq(),  0);
    lit({tag, "_done"},  int'(RESET_DONE),    exp_done(),  0);
    lit({tag, "_busy"},  int'(BUSY),          exp_busy(),  1);
    lit({tag, "_tflag"}, int'(TIMEOUT_FLAG),  exp_tflag(), 0);
  endtask

  task automatic to_edge(input int t);
    while (n < t) @(negedge CLK);
  endtask

  task automatic pulse_sw(output int s);
    SW_RST_REQ = 1'b1;
    s = n + 1;
    to_edge(s);
    SW_RST_REQ = 1'b0;
  endtask

  initial begin
    int e0, s, ack_pct;
    FABRIC_RESET_N = 1'b1;
    SW_RST_REQ     = 1'b0;
    QUIESCE_ACK    = 1'b0;
    #1 FABRIC_RESET_N = 1'b0;

    fork
      forever begin
        @(negedge CLK);
        if (chk_en) begin
          chk("stage", int'(STAGE_RESET_N), exp_stage());
          chk("qreq",  int'(QUIESCE_REQ),   exp_qreq());
          chk("done",  int'(RESET_DONE),    exp_done());
          chk("busy",  int'(BUSY),          exp_busy());
          chk("tflag", int'(TIMEOUT_FLAG),  exp_tflag());
        end
      end
    join_none

    repeat (4) @(negedge CLK);
    chk_en = 1;
    lit_reset_values("rst");

    // Power-up, with a SW request in RELEASE and an ACK in RUN that must be ignored.
    #1 FABRIC_RESET_N = 1'b1;
    e0 = n + 3;
    to_edge(e0 + 3);  lit("pu_s0", int'(STAGE_RESET_N), exp_stage(), 0);
    to_edge(e0 + 4);  lit("pu_s1", int'(STAGE_RESET_N), exp_stage(), 1);
    SW_RST_REQ = 1'b1;
    to_edge(e0 + 5);  SW_RST_REQ = 1'b0;
    to_edge(e0 + 8);  lit("pu_s2", int'(STAGE_RESET_N), exp_stage(), 3);
    to_edge(e0 + 12); lit("pu_s3", int'(STAGE_RESET_N), exp_stage(), 7);
                      lit("pu_done_early", int'(RESET_DONE), exp_done(), 0);
    to_edge(e0 + 13); lit("pu_done", int'(RESET_DONE), exp_done(), 1);
                      lit("pu_busy", int'(BUSY), exp_busy(), 0);
    QUIESCE_ACK = 1'b1;
    to_edge(e0 + 14); QUIESCE_ACK = 1'b0;
    to_edge(e0 + 16); lit("run_ack_ign", int'(QUIESCE_REQ), exp_qreq(), 0);
                      lit("run_ack_done", int'(RESET_DONE), exp_done(), 1);

    // Soft reset acknowledged five cycles after the request.
    pulse_sw(s);
    lit("ack_qreq_on", int'(QUIESCE_REQ), exp_qreq(), 1);
    to_edge(s + 4);  lit("ack_qreq_4", int'(QUIESCE_REQ), exp_qreq(), 1);
    QUIESCE_ACK = 1'b1;
    to_edge(s + 5);  QUIESCE_ACK = 1'b0;
                     lit("ack_hold_stage", int'(STAGE_RESET_N), exp_stage(), 0);
                     lit("ack_qreq_off", int'(QUIESCE_REQ), exp_qreq(), 0);
    to_edge(s + 16); lit("ack_rel_s0", int'(STAGE_RESET_N), exp_stage(), 0);
    to_edge(s + 17); lit("ack_rel_s1", int'(STAGE_RESET_N), exp_stage(), 1);
    to_edge(s + 26); lit("ack_done", int'(RESET_DONE), exp_done(), 1);
                     lit("ack_tflag", int'(TIMEOUT_FLAG), exp_tflag(), 0);

    // Soft reset with no acknowledge: timeout.
    pulse_sw(s);
    to_edge(s + 15); lit("to_qreq_15", int'(QUIESCE_REQ), exp_qreq(), 1);
                     lit("to_tflag_15", int'(TIMEOUT_FLAG), exp_tflag(), 0);
    to_edge(s + 16); lit("to_qreq_off", int'(QUIESCE_REQ), exp_qreq(), 0);
                     lit("to_tflag", int'(TIMEOUT_FLAG), exp_tflag(), 1);
                     lit("to_stage", int'(STAGE_RESET_N), exp_stage(), 0);
    to_edge(s + 36); lit("to_done_early", int'(RESET_DONE), exp_done(), 0);
    to_edge(s + 37); lit("to_done", int'(RESET_DONE), exp_done(), 1);
                     lit("to_tflag_run", int'(TIMEOUT_FLAG), exp_tflag(), 1);

    // ACK on the timeout cycle wins.
    pulse_sw(s);
    lit("sim_tflag_clr", int'(TIMEOUT_FLAG), exp_tflag(), 0);
    to_edge(s + 15); QUIESCE_ACK = 1'b1;
                     lit("sim_qreq_15", int'(QUIESCE_REQ), exp_qreq(), 1);
    to_edge(s + 16); QUIESCE_ACK = 1'b0;
                     lit("sim_qreq_off", int'(QUIESCE_REQ), exp_qreq(), 0);
                     lit("sim_tflag", int'(TIMEOUT_FLAG), exp_tflag(), 0);
                     lit("sim_stage", int'(STAGE_RESET_N), exp_stage(), 0);
    to_edge(s + 37); lit("sim_done", int'(RESET_DONE), exp_done(), 1);

    // Hard reset while only stage 0 is released; outputs drop with no clock edge.
    #1 FABRIC_RESET_N = 1'b0;
    @(negedge CLK);
    #1 FABRIC_RESET_N = 1'b1;
    e0 = n + 3;
    to_edge(e0 + 5); lit("hr_s1", int'(STAGE_RESET_N), exp_stage(), 1);
    #1 FABRIC_RESET_N = 1'b0;
    #1 lit_reset_values("hr_async");
    @(negedge CLK);
    #1 FABRIC_RESET_N = 1'b1;
    e0 = n + 3;
    to_edge(e0 + 3);  lit("hr2_s0", int'(STAGE_RESET_N), exp_stage(), 0);
    to_edge(e0 + 4);  lit("hr2_s1", int'(STAGE_RESET_N), exp_stage(), 1);
    to_edge(e0 + 13); lit("hr2_done", int'(RESET_DONE), exp_done(), 1);

    // Randomized traffic, checked every cycle against the model.
    ack_pct = 30;
    for (int i = 0; i < 900; i++) begin
      @(negedge CLK);
      if (i % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 0;
          1:       ack_pct = 5;
          default: ack_pct = 40;
        endcase
      end
      SW_RST_REQ  = ($urandom_range(0, 7) == 0);
      QUIESCE_ACK = ($urandom_range(0, 99) < ack_pct);
      if ($urandom_range(0, 199) == 0) begin
        #2 FABRIC_RESET_N = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        #2 FABRIC_RESET_N = 1'b1;
      end
    end
    @(negedge CLK);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
